ifu_fetch: RTL and testbench

- Instruction fetch unit directly upstream of the instruction decoder in the LoongArch-32 core.
- Holds the PC and issues one-outstanding-request reads to instruction memory, which can have variable latency.
- Presents the fetched instruction word with its PC and PC+4 to decode over a valid/ready handshake.
- Accepts branch/jump redirects and discards any in-flight response belonging to the old path.

---
 rtl/ifu_fetch.sv | 94 +++++++++
 tb/tb_ifu_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads
// to instruction memory and hands fetched words to decode via valid/ready.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h1C00_0000,
   parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_add4,
   input  logic        id_ready,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] inst_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] tgt;

   // Redirect targets are silently word-aligned.
   assign tgt = {br_target[31:2], 2'b00};

   // Request is decoded from state only; the address is the held PC.
   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;

   // Fetch FSM; a redirect outranks every other event in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         if_valid   <= 1'b0;
         if_inst    <= NOP_INST;
         if_pc      <= 32'h0;
         if_pc_add4 <= 32'h0;
         inst_cnt   <= 32'h0;
      end else if (br_taken) begin
         pc       <= tgt;
         if_valid <= 1'b0;
         if_inst  <= NOP_INST;
         unique case (state)
            S_IDLE:  state <= S_REQ;
            S_REQ:   state <= S_DROP;
            S_WAIT:  state <= imem_rvalid ? S_REQ : S_DROP;
            S_HOLD:  state <= S_REQ;
            S_DROP:  state <= imem_rvalid ? S_REQ : S_DROP;
            default: state <= S_IDLE;
         endcase
      end else begin
         unique case (state)
            S_IDLE: state <= S_REQ;
            S_REQ:  state <= S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  if_inst    <= imem_rdata;
                  if_pc      <= pc;
                  if_pc_add4 <= pc + 32'd4;
                  if_valid   <= 1'b1;
                  pc         <= pc + 32'd4;
                  state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (id_ready) begin
                  if_valid <= 1'b0;
                  if_inst  <= NOP_INST;
                  inst_cnt <= inst_cnt + 32'd1;
                  state    <= S_REQ;
               end
            end
            S_DROP: begin
               if (imem_rvalid) state <= S_REQ;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: variable-latency memory, random
// backpressure and redirects, checked against a transaction-level model.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h1C00_0000;
   localparam logic [31:0] NOP    = 32'h0340_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_add4;
   logic        id_ready;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] inst_cnt;

   ifu_fetch #(
      .RESET_PC(RST_PC),
      .NOP_INST(NOP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_inst    (if_inst),
      .if_pc      (if_pc),
      .if_pc_add4 (if_pc_add4),
      .id_ready   (id_ready),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .inst_cnt   (inst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk;
   int npass;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %08h want %08h", tag, got, exp);
   endtask

   // Memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0280_0401;
   endfunction

   // Model state: the outstanding memory transaction, whether its data
   // still belongs to the current path, and what decode should be seeing.
   bit          outst;
   bit          live;
   bit          exp_valid;
   bit          abort;
   int          lat;
   int          stall;
   int          cyc;
   int          first_req;
   int          first_val;
   logic [31:0] last_addr;
   logic [31:0] exp_next;
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   logic [31:0] fires;
   logic [31:0] tg [6];

   task automatic model_reset();
      outst     = 0;
      live      = 0;
      exp_valid = 0;
      lat       = 0;
      stall     = 0;
      exp_next  = RST_PC;
      exp_pc    = 32'h0;
      exp_inst  = NOP;
      fires     = 32'h0;
   endtask

   task automatic do_reset(input bit stale);
      @(negedge clk);
      rst_n       = 1'b0;
      id_ready    = 1'b0;
      br_taken    = 1'b0;
      br_target   = 32'h0;
      imem_rvalid = stale;
      imem_rdata  = 32'hDEAD_BEEF;
      #1;
      check("rst_valid", {31'b0, if_valid}, 32'h0);
      check("rst_inst", if_inst, NOP);
      check("rst_pc", if_pc, 32'h0);
      check("rst_add4", if_pc_add4, 32'h0);
      check("rst_cnt", inst_cnt, 32'h0);
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, RST_PC);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input int lat_max, input int rdy_pct,
                       input int br_pct, input int spur_pct);
      bit          resp;
      bit          fire;
      int          k;
      if (abort) return;
      @(negedge clk);
      cyc++;
      if (imem_req && first_req < 0) first_req = cyc;
      if (if_valid && first_val < 0) first_val = cyc;

      check("valid", {31'b0, if_valid}, {31'b0, exp_valid});
      check("cnt", inst_cnt, fires);
      if (exp_valid) begin
         check("pc", if_pc, exp_pc);
         check("inst", if_inst, exp_inst);
         check("add4", if_pc_add4, exp_pc + 32'd4);
      end else begin
         check("nop", if_inst, NOP);
      end
      if (imem_req) begin
         check("single", {31'b0, outst}, 32'h0);
         check("addr", imem_addr, exp_next);
      end

      resp        = 0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outst) begin
         if (lat == 0) begin
            resp        = 1;
            imem_rvalid = 1'b1;
            imem_rdata  = memf(last_addr);
         end else begin
            lat--;
         end
      end else if ($urandom_range(99, 0) < spur_pct) begin
         imem_rvalid = 1'b1;
      end
      id_ready = ($urandom_range(99, 0) < rdy_pct);
      br_taken = ($urandom_range(99, 0) < br_pct);
      k = $urandom_range(6, 0);
      br_target = (k == 6) ? $urandom : tg[k];

      if (resp) outst = 0;
      if (imem_req) begin
         outst     = 1;
         live      = 1;
         last_addr = exp_next;
         lat       = $urandom_range(lat_max - 1, 0);
      end
      fire = exp_valid && id_ready && !br_taken;
      if (br_taken) begin
         live      = 0;
         exp_valid = 0;
         exp_next  = br_target & 32'hFFFF_FFFC;
      end else if (fire) begin
         exp_valid = 0;
         fires     = fires + 32'd1;
         exp_next  = exp_pc + 32'd4;
      end else if (resp && live) begin
         exp_valid = 1;
         exp_pc    = last_addr;
         exp_inst  = imem_rdata;
         live      = 0;
      end

      if (imem_req || br_taken || (exp_valid && !id_ready)) stall = 0;
      else stall++;
      if (stall > 16) begin
         check("stall", stall, 32'h0);
         abort = 1;
      end
   endtask

   initial begin
      nchk        = 0;
      npass       = 0;
      abort       = 0;
      rst_n       = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      id_ready    = 1'b0;
      br_taken    = 1'b0;
      br_target   = 32'h0;
      tg[0] = 32'h1C00_0103;
      tg[1] = 32'h1C00_0200;
      tg[2] = 32'h1C00_0300;
      tg[3] = 32'hFFFF_FFFC;
      tg[4] = 32'hFFFF_FFFF;
      tg[5] = 32'h0000_0000;

      do_reset(0);
      cyc       = 0;
      first_req = -1;
      first_val = -1;
      repeat (8) step(1, 100, 0, 0);
      check("first_req", first_req, 32'd1);
      check("first_val", first_val, 32'd3);

      repeat (1500) step(4, 60, 5, 10);
      repeat (800) step(2, 30, 20, 5);
      repeat (500) step(1, 100, 3, 0);
      repeat (300) step(4, 80, 40, 0);

      for (int i = 0; i < 40 && !(outst && lat > 0); i++)
         step(4, 100, 0, 0);
      do_reset(1);
      repeat (300) step(3, 70, 5, 10);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
